// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon memory game sequencer.
package simon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GEN      = 3'd1,
        ST_SHOW_ON  = 3'd2,
        ST_SHOW_OFF = 3'd3,
        ST_LISTEN   = 3'd4,
        ST_OVER     = 3'd5,
        ST_WIN      = 3'd6
    } state_e;

    // Fibonacci taps 16,14,13,11 expressed as a mask over state bits [15:0].
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/simon_seq_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; advances on every clock, never gated.
module lfsr16
    import simon_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] o_state
);

    logic [15:0] r_lfsr;
    logic        w_feedback;

    assign w_feedback = ^(r_lfsr & LFSR_TAPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_feedback};
        end
    end

    assign o_state = r_lfsr;

endmodule

// File: rtl/simon_seq.sv
// Simon game sequencer: grows a random button sequence, plays it back,
// then checks the player's replay against it with a per-press timeout.
module simon_seq
    import simon_pkg::*;
#(
    parameter int          NUM_BUTTONS    = 4,
    parameter int          MAX_LEN        = 16,
    parameter int          SHOW_CYCLES    = 4,
    parameter int          GAP_CYCLES     = 2,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           player_valid,
    input  logic [$clog2(NUM_BUTTONS)-1:0] player_num,
    output logic                           simon_turn,
    output logic [$clog2(NUM_BUTTONS)-1:0] simon_num,
    output logic                           simon_pressed,
    output logic                           game_over,
    output logic                           win,
    output logic [$clog2(MAX_LEN+1)-1:0]   level
);

    localparam int BW      = $clog2(NUM_BUTTONS);
    localparam int LW      = $clog2(MAX_LEN + 1);
    localparam int IW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CNT_MAX = max3(SHOW_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
    localparam int TW      = $clog2(CNT_MAX + 1);

    localparam logic [TW-1:0] SHOW_LAST    = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST     = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [LW-1:0] LEVEL_MAX    = LW'(MAX_LEN);

    state_e        r_state;
    logic [LW-1:0] r_level;
    logic [IW-1:0] r_idx;
    logic [TW-1:0] r_timer;
    logic          r_simon_turn;
    logic [BW-1:0] r_simon_num;
    logic          r_simon_pressed;
    logic          r_game_over;
    logic          r_win;

    logic [BW-1:0] r_mem [MAX_LEN];

    logic [15:0]   w_lfsr;
    logic [BW-1:0] w_rand_num;
    logic [BW-1:0] w_first_num;
    logic [BW-1:0] w_next_num;
    logic [BW-1:0] w_expect_num;
    logic [IW-1:0] w_idx_inc;
    logic [IW-1:0] w_level_idx;
    logic          w_idx_is_last;
    logic          w_gen_we;
    logic          w_unused_lfsr;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .o_state (w_lfsr)
    );

    assign w_rand_num    = w_lfsr[BW-1:0];
    assign w_unused_lfsr = ^w_lfsr[15:BW];

    assign w_level_idx   = r_level[IW-1:0];
    assign w_idx_inc     = r_idx + IW'(1);
    assign w_idx_is_last = (LW'(r_idx) == (r_level - LW'(1)));
    assign w_next_num    = r_mem[w_idx_inc];
    assign w_expect_num  = r_mem[r_idx];
    // On the first round entry 0 is being written this very cycle, so bypass it.
    assign w_first_num   = (r_level == '0) ? w_rand_num : r_mem[0];

    assign w_gen_we = (r_state == ST_GEN);

    // Sequence storage; no reset because only entries below level are read.
    always_ff @(posedge clk) begin
        if (w_gen_we) begin
            r_mem[w_level_idx] <= w_rand_num;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_level         <= '0;
            r_idx           <= '0;
            r_timer         <= '0;
            r_simon_turn    <= 1'b0;
            r_simon_num     <= '0;
            r_simon_pressed <= 1'b0;
            r_game_over     <= 1'b0;
            r_win           <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_OVER, ST_WIN: begin
                    if (start) begin
                        r_state      <= ST_GEN;
                        r_level      <= '0;
                        r_idx        <= '0;
                        r_timer      <= '0;
                        r_game_over  <= 1'b0;
                        r_win        <= 1'b0;
                        r_simon_turn <= 1'b1;
                    end
                end

                ST_GEN: begin
                    r_level         <= r_level + LW'(1);
                    r_idx           <= '0;
                    r_timer         <= '0;
                    r_simon_num     <= w_first_num;
                    r_simon_pressed <= 1'b1;
                    r_state         <= ST_SHOW_ON;
                end

                ST_SHOW_ON: begin
                    if (r_timer == SHOW_LAST) begin
                        r_timer         <= '0;
                        r_simon_pressed <= 1'b0;
                        r_state         <= ST_SHOW_OFF;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end

                ST_SHOW_OFF: begin
                    if (r_timer == GAP_LAST) begin
                        r_timer <= '0;
                        if (w_idx_is_last) begin
                            r_idx        <= '0;
                            r_simon_turn <= 1'b0;
                            r_state      <= ST_LISTEN;
                        end else begin
                            r_idx           <= w_idx_inc;
                            r_simon_num     <= w_next_num;
                            r_simon_pressed <= 1'b1;
                            r_state         <= ST_SHOW_ON;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end

                ST_LISTEN: begin
                    // A press on the final timeout cycle takes priority over the timeout.
                    if (player_valid) begin
                        r_timer <= '0;
                        if (player_num != w_expect_num) begin
                            r_game_over <= 1'b1;
                            r_state     <= ST_OVER;
                        end else if (!w_idx_is_last) begin
                            r_idx <= w_idx_inc;
                        end else if (r_level == LEVEL_MAX) begin
                            r_win   <= 1'b1;
                            r_state <= ST_WIN;
                        end else begin
                            r_simon_turn <= 1'b1;
                            r_state      <= ST_GEN;
                        end
                    end else if (r_timer == TIMEOUT_LAST) begin
                        r_timer     <= '0;
                        r_game_over <= 1'b1;
                        r_state     <= ST_OVER;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign simon_turn    = r_simon_turn;
    assign simon_num     = r_simon_num;
    assign simon_pressed = r_simon_pressed;
    assign game_over     = r_game_over;
    assign win           = r_win;
    assign level         = r_level;

endmodule

// File: tb/tb_simon_seq.sv
// Randomized scoreboard bench for simon_seq with a game-level reference model.
`timescale 1ns/1ps
module tb_simon_seq;

    localparam int          NB      = 4;
    localparam int          BW      = $clog2(NB);
    localparam int          MAX_LEN = 4;
    localparam int          LW      = $clog2(MAX_LEN + 1);
    localparam int          SHOW    = 3;
    localparam int          GAP     = 2;
    localparam int          TO      = 10;
    localparam logic [15:0] SEED    = 16'hACE1;
    localparam int          N_GAMES = 40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          player_valid = 1'b0;
    logic [BW-1:0] player_num = '0;
    logic          simon_turn;
    logic [BW-1:0] simon_num;
    logic          simon_pressed;
    logic          game_over;
    logic          win;
    logic [LW-1:0] level;

    int checks = 0;
    int failures = 0;

    int          seq_m[$];   // the game sequence as the model sees it
    int          exp_q[$];   // expected playback buttons, in order
    logic [15:0] m_lfsr;

    simon_seq #(
        .NUM_BUTTONS    (NB),
        .MAX_LEN        (MAX_LEN),
        .SHOW_CYCLES    (SHOW),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TO),
        .LFSR_SEED      (SEED)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .player_valid  (player_valid),
        .player_num    (player_num),
        .simon_turn    (simon_turn),
        .simon_num     (simon_num),
        .simon_pressed (simon_pressed),
        .game_over     (game_over),
        .win           (win),
        .level         (level)
    );

    always #5 clk = ~clk;

    // Taps 16,14,13,11 -> state bits 15,13,12,10, shifting toward the MSB.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= lfsr_next(m_lfsr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, want);
        end
    endtask

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // Monitor: one line per playback step, widths of lit and dark phases.
    logic prev_pressed = 1'b0;
    int   hi_cnt = 0;
    int   lo_cnt = 0;
    bit   in_gap = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_pressed = 1'b0;
            hi_cnt       = 0;
            lo_cnt       = 0;
            in_gap       = 1'b0;
        end else begin
            if (simon_pressed) begin
                if (!prev_pressed) begin
                    if (in_gap) chk("gap_len", lo_cnt, GAP);
                    in_gap = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL playback_unexpected actual=%0d expected=no_step", simon_num);
                    end else begin
                        int want;
                        want = exp_q.pop_front();
                        $display("playback step num=%0d expected=%0d level=%0d", simon_num, want, level);
                        chk("playback_num", simon_num, want);
                    end
                    hi_cnt = 0;
                end
                hi_cnt++;
            end else begin
                if (prev_pressed) begin
                    chk("show_len", hi_cnt, SHOW);
                    in_gap = 1'b1;
                    lo_cnt = 0;
                end
                if (in_gap) begin
                    if (simon_turn) lo_cnt++;
                    else begin
                        chk("gap_len", lo_cnt, GAP);
                        in_gap = 1'b0;
                    end
                end
            end
            prev_pressed = simon_pressed;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at the negedge of the GEN cycle: the new step is the current LFSR value.
    task automatic begin_round();
        seq_m.push_back(int'(m_lfsr[BW-1:0]));
        foreach (seq_m[i]) exp_q.push_back(seq_m[i]);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_gen_turn", simon_turn, 1);
        chk("start_level_cleared", level, 0);
        chk("start_clears_over", game_over, 0);
        chk("start_clears_win", win, 0);
        seq_m.delete();
        begin_round();
    endtask

    task automatic wait_listen();
        int n;
        n = 0;
        while (simon_turn === 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 500) begin
                checks++;
                failures++;
                $display("FAIL listen_wait actual=%0d expected=at_most_500", n);
                finish_run();
            end
        end
        chk("playback_all_shown", exp_q.size(), 0);
        chk("listen_level", level, seq_m.size());
    endtask

    task automatic press(input int num);
        player_valid = 1'b1;
        player_num   = BW'(num);
        @(negedge clk);
        player_valid = 1'b0;
        $display("press num=%0d -> game_over=%0d win=%0d turn=%0d level=%0d",
                 num, game_over, win, simon_turn, level);
    endtask

    task automatic check_timeout(input int lvl);
        int c;
        c = 0;
        while (game_over !== 1'b1 && c <= TO + 2) begin
            @(negedge clk);
            c++;
        end
        $display("timeout after %0d cycles level=%0d", c, level);
        chk("timeout_cycles", c, TO);
        chk("timeout_level", level, lvl);
    endtask

    task automatic play_listen(input int fault_pct, output bit ended);
        int lvl;
        bit done;
        int r;
        lvl  = seq_m.size();
        done = 1'b0;
        wait_listen();
        for (int i = 0; i < lvl && !done; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < fault_pct / 2) begin
                check_timeout(lvl);
                done = 1'b1;
            end else if (r < fault_pct) begin
                idle(int'($urandom_range(0, TO - 1)));
                press(int'((seq_m[i] + 1 + int'($urandom_range(0, NB - 2))) % NB));
                chk("wrong_over", game_over, 1);
                chk("wrong_level", level, lvl);
                chk("wrong_turn", simon_turn, 0);
                chk("wrong_win", win, 0);
                done = 1'b1;
            end else begin
                idle(int'($urandom_range(0, TO - 1)));
                press(seq_m[i]);
                if (i < lvl - 1) begin
                    chk("mid_press_over", game_over, 0);
                    chk("mid_press_turn", simon_turn, 0);
                end else if (lvl == MAX_LEN) begin
                    chk("win_flag", win, 1);
                    chk("win_level", level, MAX_LEN);
                    chk("win_over", game_over, 0);
                    done = 1'b1;
                end else begin
                    chk("next_round_turn", simon_turn, 1);
                    begin_round();
                end
            end
        end
        ended = done;
    endtask

    initial begin
        #1_000_000;
        checks++;
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish");
        finish_run();
    end

    initial begin
        bit ended;

        // Reset state
        idle(3);
        chk("rst_turn", simon_turn, 0);
        chk("rst_pressed", simon_pressed, 0);
        chk("rst_num", simon_num, 0);
        chk("rst_over", game_over, 0);
        chk("rst_win", win, 0);
        chk("rst_level", level, 0);
        rst_n = 1'b1;
        idle(2);
        chk("idle_stays", simon_turn, 0);

        // Start latency, ignored press during playback, press on the last allowed cycle
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("gen_turn", simon_turn, 1);
        chk("gen_pressed", simon_pressed, 0);
        seq_m.delete();
        begin_round();
        @(negedge clk);
        chk("show_latency", simon_pressed, 1);
        chk("show_level", level, 1);
        press((seq_m[0] + 1) % NB);
        wait_listen();
        chk("ignored_press_over", game_over, 0);
        idle(TO - 1);
        press(seq_m[0]);
        chk("boundary_press_turn", simon_turn, 1);
        chk("boundary_press_over", game_over, 0);
        begin_round();

        // Start ignored in LISTEN, then wrong button on step 2 of level 2
        wait_listen();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_listen_turn", simon_turn, 0);
        chk("start_in_listen_level", level, 2);
        press(seq_m[0]);
        chk("step1_ok_over", game_over, 0);
        press((seq_m[1] + 1) % NB);
        chk("wrong_step2_over", game_over, 1);
        chk("wrong_step2_level", level, 2);
        press(seq_m[1]);
        idle(2);
        chk("press_in_over_ignored", game_over, 1);
        chk("press_in_over_level", level, 2);
        chk("press_in_over_turn", simon_turn, 0);

        // Restart from OVER, then a full timeout
        do_start();
        wait_listen();
        chk("restart_over", game_over, 0);
        check_timeout(1);

        // Clean game to the win
        do_start();
        do play_listen(0, ended); while (!ended);
        press(seq_m[0]);
        idle(1);
        chk("win_held", win, 1);
        chk("win_level_held", level, MAX_LEN);

        // Asynchronous reset in the middle of SHOW_ON
        do_start();
        begin
            int n;
            n = 0;
            while (simon_pressed !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("reach_show_on", simon_pressed, 1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_turn", simon_turn, 0);
        chk("rst_mid_pressed", simon_pressed, 0);
        chk("rst_mid_num", simon_num, 0);
        chk("rst_mid_over", game_over, 0);
        chk("rst_mid_win", win, 0);
        chk("rst_mid_level", level, 0);
        exp_q.delete();
        seq_m.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_start();
        wait_listen();
        check_timeout(1);

        // Randomized games
        for (int g = 0; g < N_GAMES; g++) begin
            do_start();
            do play_listen(25, ended); while (!ended);
        end

        idle(2);
        finish_run();
    end

endmodule

// File: doc/simon_seq.md
SIMON_SEQ -- requirements
Module: simon_seq

Interface
REQ-001 Parameter NUM_BUTTONS, default 4, number of buttons; SHALL be 2, 4 or 8; BW = log2(NUM_BUTTONS).
REQ-002 Parameter MAX_LEN, default 16, longest sequence; reaching it wins; LW = $clog2(MAX_LEN+1).
REQ-003 Parameter SHOW_CYCLES, default 4, cycles each playback step is lit.
REQ-004 Parameter GAP_CYCLES, default 2, dark cycles after each playback step.
REQ-005 Parameter TIMEOUT_CYCLES, default 1000, max cycles between player presses.
REQ-006 Parameter LFSR_SEED, default 16'hACE1, nonzero LFSR reset value.
REQ-007 clk  in  1  single clock, rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 start  in  1  pulse; starts a new game from IDLE, OVER or WIN.
REQ-010 player_valid  in  1  single-cycle pulse per player press.
REQ-011 player_num  in  BW  button pressed, valid with player_valid.
REQ-012 simon_turn  out  1  high while the block generates or plays back.
REQ-013 simon_num  out  BW  button being played back.
REQ-014 simon_pressed  out  1  playback button lit.
REQ-015 game_over  out  1  held high after mismatch or timeout.
REQ-016 win  out  1  held high after MAX_LEN steps replayed correctly.
REQ-017 level  out  LW  current sequence length.

Function
REQ-018 States: IDLE, GEN, SHOW_ON, SHOW_OFF, LISTEN, OVER, WIN; all outputs registered.
REQ-019 16-bit Fibonacci LFSR, taps 16,14,13,11, SHALL shift every clock in all states.
REQ-020 IDLE/OVER/WIN: start -> GEN, clear level, game_over, win; start in any other state ignored.
REQ-021 GEN (one cycle): mem[level] <= lfsr[BW-1:0]; level++; idx <= 0; -> SHOW_ON.
REQ-022 SHOW_ON: simon_pressed=1, simon_num=mem[idx] for exactly SHOW_CYCLES cycles, then -> SHOW_OFF.
REQ-023 SHOW_OFF: simon_pressed=0 for exactly GAP_CYCLES cycles; if idx==level-1 -> LISTEN with idx=0, timer=0; else idx++, -> SHOW_ON.
REQ-024 simon_turn SHALL be 1 in GEN, SHOW_ON and SHOW_OFF, else 0.
REQ-025 LISTEN, player_valid with player_num==mem[idx]: timer=0; if idx<level-1 then idx++; else -> WIN if level==MAX_LEN, otherwise -> GEN.
REQ-026 LISTEN, player_valid with mismatch: -> OVER, game_over=1 the next cycle, level unchanged.
REQ-027 LISTEN, no player_valid for TIMEOUT_CYCLES consecutive cycles: -> OVER.
REQ-028 player_valid and timeout on the same cycle: the press wins.
REQ-029 player_valid outside LISTEN SHALL be ignored; it is not queued.
REQ-030 Counters SHALL be wide enough for max(SHOW_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES); no wrap.
REQ-031 Latency: start sampled at edge k -> GEN after k; simon_pressed high after edge k+1.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, all outputs 0, level 0, idx 0, timers 0, LFSR=LFSR_SEED, from any state.
REQ-033 Sequence memory SHALL NOT need reset; entries beyond level are never read.

Structure
REQ-034 Package simon_pkg SHALL hold the state enum and the LFSR tap constant.
REQ-035 Sub-module lfsr16 (seed parameter, enable-free, 16-bit state output) SHALL be instantiated once.
REQ-036 Sequence memory SHALL be a MAX_LEN x BW register array inside simon_seq.

Verification
REQ-037 Reset mid-SHOW_ON -> all outputs 0 the same cycle rst_n falls; start after release replays from level 1.
REQ-038 SHOW=3, GAP=2, start -> simon_pressed high exactly 3 cycles with simon_num=LFSR-model value; simon_turn low 2 cycles later; level=1.
REQ-039 MAX_LEN=2, correct replies in both rounds -> second round plays 2 steps; win=1, level=2, game_over=0.
REQ-040 Wrong button on step 2 of level 2 -> game_over=1 next cycle, level stays 2, later presses ignored.
REQ-041 TIMEOUT=10, no press -> game_over=1 exactly 10 cycles after entering LISTEN; press on cycle 10 -> no timeout.
REQ-042 player_valid during SHOW_ON and start during LISTEN -> no effect; start in OVER -> level=1, game_over=0.
